// File: rtl/data_checker.sv
// -----------------------------------------------------------------------------
// data_checker
//   Read-back checker for a pattern generator. After `initialize` loads a seed,
//   every accepted beat (data_valid && data_ready) is compared byte-wise against
//   the locally regenerated expected pattern. The expected pattern then advances
//   exactly as the generator does: parallel Galois LFSR lanes or a 1-bit rotate.
//   Results are registered one cycle after the accept cycle.
//
//   Handshake: a beat is transferred on a rising clock edge when data_valid and
//   data_ready are both 1. data_ready is 1 only in RUN and only while initialize
//   is low. data_valid is ignored while data_ready is 0.
//
// Parameters
//   WIDTH        beat width (multiple of LFSR_WIDTH and of 8)
//   SHIFT_LOG2   accepted for generator compatibility, no effect
//   LFSR_WIDTH   width of each independent LFSR lane
//   LFSR_TAPS    tap mask XORed into lane bits [LFSR_WIDTH-2:0]
//   COUNT_WIDTH  width of error_count (saturating)
//
// Ports
//   clock, resetn           clock (rising edge), async active-low reset
//   initialize, initial_value   load seed, clear beat_count, enter RUN
//   mode_selector           1 = LFSR, 0 = shift
//   shift_enable, shift_direction  shift mode controls (1 = rotate right)
//   final_byte_mask         1 = byte takes part in the comparison
//   clear_status            clear sticky status and first-error capture
//   data_valid, data_in, data_ready  read-back beat handshake
//   mismatch_pulse, error_flag, error_count, beat_count  results
//   first_error_index, first_error_bytes  first failing beat capture
//
// Configuration
//   DATA_CHECKER_FIRST_ERROR_CAPTURE_EN  defined: first-error capture present;
//   undefined: first_error_index/first_error_bytes are constant 0.
// -----------------------------------------------------------------------------
module data_checker #(
  parameter int                    WIDTH       = 256,
  parameter int                    SHIFT_LOG2  = 2,
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-2:0] LFSR_TAPS   = 31'b0100011000000000000000000000000,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   initialize,
  input  logic [WIDTH-1:0]       initial_value,
  input  logic                   mode_selector,
  input  logic                   shift_enable,
  input  logic                   shift_direction,
  input  logic [WIDTH/8-1:0]     final_byte_mask,
  input  logic                   clear_status,
  input  logic                   data_valid,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   data_ready,
  output logic                   mismatch_pulse,
  output logic                   error_flag,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [31:0]            beat_count,
  output logic [31:0]            first_error_index,
  output logic [WIDTH/8-1:0]     first_error_bytes
);

  // SHIFT_LOG2 has no effect on the checker; it is folded in with weight 0.
  localparam int NB = WIDTH / 8 + (SHIFT_LOG2 * 0);
  localparam int NL = WIDTH / LFSR_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       expected_q, expected_d;
  logic [31:0]            beat_count_q, beat_count_d;
  logic                   mismatch_pulse_q, mismatch_pulse_d;
  logic                   error_flag_q, error_flag_d;
  logic [COUNT_WIDTH-1:0] error_count_q, error_count_d;

  logic                   accept;
  logic                   fail;
  logic [NB-1:0]          mismatch;
  logic [WIDTH-1:0]       lfsr_next;
  logic [WIDTH-1:0]       rot_left;
  logic [WIDTH-1:0]       rot_right;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (initialize) state_d = S_RUN;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    data_ready = (state_q == S_RUN) && !initialize;
  end

  assign accept = data_valid && data_ready;

  // Per-byte compare against the current expected beat.
  always_comb begin
    mismatch = '0;
    for (int i = 0; i < NB; i++) begin
      mismatch[i] = final_byte_mask[i] && (expected_q[8*i +: 8] != data_in[8*i +: 8]);
    end
  end

  assign fail = accept && (|mismatch);

  // Galois step per lane: lane bit 0 feeds back into the MSB and the taps.
  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign lfsr_next[k*LFSR_WIDTH +: LFSR_WIDTH] =
      {expected_q[k*LFSR_WIDTH],
       ({(LFSR_WIDTH-1){expected_q[k*LFSR_WIDTH]}} & LFSR_TAPS)
       ^ expected_q[k*LFSR_WIDTH+1 +: LFSR_WIDTH-1]};
  end

  assign rot_left  = {expected_q[WIDTH-2:0], expected_q[WIDTH-1]};
  assign rot_right = {expected_q[0], expected_q[WIDTH-1:1]};

  // Expected pattern and beat counter.
  always_comb begin
    expected_d   = expected_q;
    beat_count_d = beat_count_q;
    if (initialize) begin
      expected_d   = initial_value;
      beat_count_d = '0;
    end else if (accept) begin
      beat_count_d = beat_count_q + 32'd1;
      if (mode_selector)     expected_d = lfsr_next;
      else if (shift_enable) expected_d = shift_direction ? rot_right : rot_left;
    end
  end

  // Sticky status. clear_status acts first so a failing beat in the same
  // cycle still counts as the first error after the clear.
  always_comb begin
    mismatch_pulse_d = fail;
    error_flag_d     = error_flag_q;
    error_count_d    = error_count_q;
    if (clear_status) begin
      error_flag_d  = 1'b0;
      error_count_d = '0;
    end
    if (fail) begin
      error_flag_d = 1'b1;
      if (!(&error_count_d)) error_count_d = error_count_d + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      expected_q       <= '0;
      beat_count_q     <= '0;
      mismatch_pulse_q <= 1'b0;
      error_flag_q     <= 1'b0;
      error_count_q    <= '0;
    end else begin
      expected_q       <= expected_d;
      beat_count_q     <= beat_count_d;
      mismatch_pulse_q <= mismatch_pulse_d;
      error_flag_q     <= error_flag_d;
      error_count_q    <= error_count_d;
    end
  end

`ifdef DATA_CHECKER_FIRST_ERROR_CAPTURE_EN
  logic [31:0]   first_index_q, first_index_d;
  logic [NB-1:0] first_bytes_q, first_bytes_d;

  // Capture only the first failure since reset or the last clear_status.
  always_comb begin
    first_index_d = clear_status ? '0 : first_index_q;
    first_bytes_d = clear_status ? '0 : first_bytes_q;
    if (fail && (clear_status || !error_flag_q)) begin
      first_index_d = beat_count_q;
      first_bytes_d = mismatch;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      first_index_q <= '0;
      first_bytes_q <= '0;
    end else begin
      first_index_q <= first_index_d;
      first_bytes_q <= first_bytes_d;
    end
  end

  assign first_error_index = first_index_q;
  assign first_error_bytes = first_bytes_q;
`else
  assign first_error_index = '0;
  assign first_error_bytes = '0;
`endif

  assign mismatch_pulse = mismatch_pulse_q;
  assign error_flag     = error_flag_q;
  assign error_count    = error_count_q;
  assign beat_count     = beat_count_q;

endmodule

// File: tb/tb_data_checker.sv
// -----------------------------------------------------------------------------
// tb_data_checker
//   Directed bench for data_checker (WIDTH=64, two 32-bit LFSR lanes,
//   COUNT_WIDTH=4). A behavioural model tracks the expected outputs and a
//   compare process checks them every falling edge; literal expectations pin
//   the model on the hand-computed scenarios.
// -----------------------------------------------------------------------------
module tb_data_checker;
  localparam int W  = 64;
  localparam int NB = W / 8;
  localparam int CW = 4;
  localparam logic [31:0] POLY = 32'hA300_0000;  // {1, taps} as a right-shift feedback word

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic          initialize      = 1'b0;
  logic [W-1:0]  initial_value   = '0;
  logic          mode_selector   = 1'b0;
  logic          shift_enable    = 1'b0;
  logic          shift_direction = 1'b0;
  logic [NB-1:0] final_byte_mask = '1;
  logic          clear_status    = 1'b0;
  logic          data_valid      = 1'b0;
  logic [W-1:0]  data_in         = '0;
  logic          data_ready;
  logic          mismatch_pulse;
  logic          error_flag;
  logic [CW-1:0] error_count;
  logic [31:0]   beat_count;
  logic [31:0]   first_error_index;
  logic [NB-1:0] first_error_bytes;

  data_checker #(.WIDTH(W), .LFSR_WIDTH(32), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .resetn(resetn),
    .initialize(initialize), .initial_value(initial_value),
    .mode_selector(mode_selector), .shift_enable(shift_enable),
    .shift_direction(shift_direction), .final_byte_mask(final_byte_mask),
    .clear_status(clear_status), .data_valid(data_valid), .data_in(data_in),
    .data_ready(data_ready), .mismatch_pulse(mismatch_pulse),
    .error_flag(error_flag), .error_count(error_count), .beat_count(beat_count),
    .first_error_index(first_error_index), .first_error_bytes(first_error_bytes)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulses_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model helpers ----------------
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [31:0]  l;
    for (int k = 0; k < W / 32; k++) begin
      l = v[k*32 +: 32];
      r[k*32 +: 32] = (l >> 1) ^ (l[0] ? POLY : 32'h0);
    end
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  logic          exp_q[$];           // expected mismatch_pulse, one entry per clock
  logic          m_run   = 1'b0;
  logic [W-1:0]  m_exp   = '0;
  logic [31:0]   m_beats = '0;
  logic          m_flag  = 1'b0;
  int            m_errs  = 0;
  logic [31:0]   m_idx   = '0;
  logic [NB-1:0] m_bytes = '0;

  always @(posedge clock or negedge resetn) begin
    logic          acc;
    logic [NB-1:0] fb;
    logic          old_flag;
    if (!resetn) begin
      m_run = 0; m_exp = '0; m_beats = '0; m_flag = 0; m_errs = 0;
      m_idx = '0; m_bytes = '0; exp_q.delete();
    end else begin
      acc = data_valid && m_run && !initialize;
      fb  = '0;
      if (acc)
        for (int i = 0; i < NB; i++)
          if (final_byte_mask[i] && (m_exp[8*i +: 8] != data_in[8*i +: 8])) fb[i] = 1'b1;
      exp_q.push_back(fb != '0);
      old_flag = m_flag;
      if (clear_status) begin
        m_flag = 0; m_errs = 0; m_idx = '0; m_bytes = '0;
      end
      if (fb != '0) begin
        if (clear_status || !old_flag) begin m_idx = m_beats; m_bytes = fb; end
        m_flag = 1;
        m_errs++;
      end
      if (initialize) begin
        m_run = 1; m_exp = initial_value; m_beats = '0;
      end else if (acc) begin
        m_beats++;
        if (mode_selector)     m_exp = lfsr_step(m_exp);
        else if (shift_enable) m_exp = shift_direction ? ((m_exp >> 1) | (m_exp << (W-1)))
                                                       : ((m_exp << 1) | (m_exp >> (W-1)));
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    logic ep;
    ep = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
    if (mismatch_pulse === 1'b1) pulses_seen++;
    chk("data_ready", 64'(data_ready), 64'(resetn && m_run && !initialize));
    chk("mismatch_pulse", 64'(mismatch_pulse), 64'(ep));
    chk("error_flag", 64'(error_flag), 64'(m_flag));
    chk("error_count", 64'(error_count), 64'((m_errs > 15) ? 15 : m_errs));
    chk("beat_count", 64'(beat_count), 64'(m_beats));
`ifdef DATA_CHECKER_FIRST_ERROR_CAPTURE_EN
    chk("first_error_index", 64'(first_error_index), 64'(m_idx));
    chk("first_error_bytes", 64'(first_error_bytes), 64'(m_bytes));
`else
    chk("first_error_index", 64'(first_error_index), 64'(0));
    chk("first_error_bytes", 64'(first_error_bytes), 64'(0));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clock); #1;
    resetn = 1'b0;
    initialize = 0; data_valid = 0; clear_status = 0; final_byte_mask = '1;
    #2;
    chk("reset_ready", 64'(data_ready), 64'(0));
    chk("reset_beats", 64'(beat_count), 64'(0));
    chk("reset_errs", 64'(error_count), 64'(0));
    chk("reset_flag", 64'(error_flag), 64'(0));
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  task automatic init_pattern(input logic [W-1:0] seed, input logic mode,
                              input logic en, input logic dir);
    initialize = 1; initial_value = seed;
    mode_selector = mode; shift_enable = en; shift_direction = dir;
    @(posedge clock); #1;
    initialize = 0;
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic clr);
    data_valid = 1; data_in = d; clear_status = clr;
    @(posedge clock); #1;
    data_valid = 0; clear_status = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] g;
  logic [W-1:0] d;
  int           p0;
  initial begin
    // Pin the LFSR model with hand-computed steps.
    chk("lfsr_pin1", lfsr_step(64'h0000_0001_0000_0001), 64'hA300_0000_A300_0000);
    chk("lfsr_pin2", lfsr_step(64'hA300_0000_A300_0000), 64'h5180_0000_5180_0000);

    // No initialize: valid is ignored for 10 cycles.
    do_reset();
    data_valid = 1; data_in = 64'h1234;
    idle(10);
    data_valid = 0;
    @(negedge clock);
    chk("idle_ready", 64'(data_ready), 64'(0));
    chk("idle_beats", 64'(beat_count), 64'(0));
    chk("idle_errs", 64'(error_count), 64'(0));

    // Shift left, clean stream.
    do_reset();
    init_pattern(64'h1, 1'b0, 1'b1, 1'b0);
    p0 = pulses_seen;
    send_beat(64'h1, 0); send_beat(64'h2, 0); send_beat(64'h4, 0); send_beat(64'h8, 0);
    @(negedge clock);
    chk("shl_beats", 64'(beat_count), 64'(4));
    chk("shl_pulses", 64'(pulses_seen - p0), 64'(0));

    // Shift left, beat 2 corrupted in byte 1.
    do_reset();
    init_pattern(64'h1, 1'b0, 1'b1, 1'b0);
    send_beat(64'h1, 0); send_beat(64'h2, 0); send_beat(64'h104, 0);
    @(negedge clock);
    chk("corrupt_pulse", 64'(mismatch_pulse), 64'(1));
    send_beat(64'h8, 0);
    @(negedge clock);
    chk("corrupt_pulse_off", 64'(mismatch_pulse), 64'(0));
    chk("corrupt_errs", 64'(error_count), 64'(1));
`ifdef DATA_CHECKER_FIRST_ERROR_CAPTURE_EN
    chk("corrupt_idx", 64'(first_error_index), 64'(2));
    chk("corrupt_bytes", 64'(first_error_bytes), 64'(8'h02));
`else
    chk("corrupt_idx", 64'(first_error_index), 64'(0));
    chk("corrupt_bytes", 64'(first_error_bytes), 64'(0));
`endif

    // Same corruption with byte 1 masked off.
    do_reset();
    final_byte_mask = 8'hFD;
    init_pattern(64'h1, 1'b0, 1'b1, 1'b0);
    send_beat(64'h1, 0); send_beat(64'h2, 0); send_beat(64'h104, 0); send_beat(64'h8, 0);
    @(negedge clock);
    chk("masked_errs", 64'(error_count), 64'(0));
    chk("masked_flag", 64'(error_flag), 64'(0));
    final_byte_mask = '1;

    // Rotate right across the wrap, hold with shift_enable=0, initialize+valid.
    do_reset();
    init_pattern(64'h1, 1'b0, 1'b1, 1'b1);
    send_beat(64'h1, 0); send_beat(64'h8000_0000_0000_0000, 0);
    shift_enable = 0;
    send_beat(64'h4000_0000_0000_0000, 0); send_beat(64'h4000_0000_0000_0000, 0);
    @(negedge clock);
    chk("rotr_errs", 64'(error_count), 64'(0));
    chk("rotr_beats", 64'(beat_count), 64'(4));
    initialize = 1; initial_value = 64'hFF; data_valid = 1; data_in = 64'h0;
    @(posedge clock); #1;
    initialize = 0; data_valid = 0;
    @(negedge clock);
    chk("init_valid_beats", 64'(beat_count), 64'(0));
    chk("init_valid_errs", 64'(error_count), 64'(0));

    // Reset mid-run: a fresh initialize is needed afterwards.
    send_beat(64'hFF, 0);
    do_reset();
    send_beat(64'hFF, 0);
    @(negedge clock);
    chk("post_reset_beats", 64'(beat_count), 64'(0));

    // LFSR, 100 beats, bit flip at 50, clear+fail at 60.
    do_reset();
    g = 64'h0000_0001_0000_0001;
    init_pattern(g, 1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 100; b++) begin
      d = g;
      if (b == 50) d = d ^ 64'h80;
      if (b == 60) d = d ^ 64'h8;
      send_beat(d, b == 60);
      g = lfsr_step(g);
      if (b == 59) begin
        @(negedge clock);
        chk("lfsr_errs_50", 64'(error_count), 64'(1));
`ifdef DATA_CHECKER_FIRST_ERROR_CAPTURE_EN
        chk("lfsr_idx_50", 64'(first_error_index), 64'(50));
`else
        chk("lfsr_idx_50", 64'(first_error_index), 64'(0));
`endif
        #1;
      end
    end
    @(negedge clock);
    chk("lfsr_errs_60", 64'(error_count), 64'(1));
    chk("lfsr_beats", 64'(beat_count), 64'(100));
`ifdef DATA_CHECKER_FIRST_ERROR_CAPTURE_EN
    chk("lfsr_idx_60", 64'(first_error_index), 64'(60));
`else
    chk("lfsr_idx_60", 64'(first_error_index), 64'(0));
`endif

    // Saturation with COUNT_WIDTH=4.
    do_reset();
    init_pattern(64'hAA, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 20; b++) send_beat(64'h55, 0);
    @(negedge clock);
    chk("sat_errs", 64'(error_count), 64'(15));
    chk("sat_flag", 64'(error_flag), 64'(1));
    chk("sat_beats", 64'(beat_count), 64'(20));
`ifndef DATA_CHECKER_FIRST_ERROR_CAPTURE_EN
    chk("sat_idx_zero", 64'(first_error_index), 64'(0));
    chk("sat_bytes_zero", 64'(first_error_bytes), 64'(0));
`endif
    // clear_status alone empties the sticky status.
    clear_status = 1;
    @(posedge clock); #1;
    clear_status = 0;
    @(negedge clock);
    chk("clear_errs", 64'(error_count), 64'(0));
    chk("clear_flag", 64'(error_flag), 64'(0));

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
